// File: rtl/decoder_seq_if.sv
// decoder_seq_if: select/mode request and registered one-hot response bundle for decoder_seq
interface decoder_seq_if #(parameter int SEL_W = 3);
  logic E;
  logic load;
  logic clr;
  logic [SEL_W-1:0] s;
  logic [1:0] mode;
  logic [2**SEL_W-1:0] Y;
  logic [SEL_W-1:0] idx;
  logic busy;
  modport master (output E, load, clr, s, mode, input Y, idx, busy);
  modport slave (input E, load, clr, s, mode, output Y, idx, busy);
endinterface

// File: rtl/decoder_seq.sv
// decoder_seq: registered one-hot decoder that holds, rotates or pulses a latched select
module decoder_seq #(
  parameter int SEL_W = 3,
  parameter int PULSE_LEN = 4
) (
  input logic clk,
  input logic rst_n,
  decoder_seq_if.slave bus
);
  localparam int OUT_W = 2**SEL_W;
  localparam int CW = PULSE_LEN > 1 ? $clog2(PULSE_LEN) : 1;
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_n;
  logic [SEL_W-1:0] idx_r, idx_n;
  logic [OUT_W-1:0] y_r, y_n;
  logic [1:0] mode_r, mode_n;
  logic [CW-1:0] cnt, cnt_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      idx_r <= '0;
      y_r <= '0;
      mode_r <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      idx_r <= idx_n;
      y_r <= y_n;
      mode_r <= mode_n;
      cnt <= cnt_n;
    end
  // Y is always re-derived from the next index so it stays consistent with idx
  always_comb begin
    state_n = state;
    idx_n = idx_r;
    y_n = y_r;
    mode_n = mode_r;
    cnt_n = cnt;
    if (bus.clr) begin
      state_n = IDLE;
      y_n = '0;
      cnt_n = '0;
    end else if (bus.load && bus.E) begin
      state_n = ACTIVE;
      idx_n = bus.s;
      mode_n = bus.mode;
      cnt_n = CW'(PULSE_LEN - 1);
      y_n = OUT_W'(1) << bus.s;
    end else if (state == ACTIVE && bus.E) begin
      idx_n = mode_r == 2'b01 ? idx_r + SEL_W'(1) :
              mode_r == 2'b10 ? idx_r - SEL_W'(1) : idx_r;
      y_n = OUT_W'(1) << idx_n;
      if (mode_r == 2'b11) begin
        state_n = cnt == '0 ? IDLE : ACTIVE;
        y_n = cnt == '0 ? '0 : y_r;
        cnt_n = cnt == '0 ? cnt : cnt - CW'(1);
      end
    end
  end
  assign bus.Y = y_r;
  assign bus.idx = idx_r;
  assign bus.busy = state == ACTIVE;
endmodule

// File: tb/tb_decoder_seq.sv
// tb_decoder_seq: directed checks of decode, rotate, pulse, priority, async reset and parameter corners
module tb_decoder_seq;
  logic clk = 0;
  logic rst_n = 0;
  int checks = 0;
  int failures = 0;
  decoder_seq_if #(.SEL_W(3)) a_if ();
  decoder_seq_if #(.SEL_W(1)) b_if ();
  decoder_seq_if #(.SEL_W(4)) c_if ();
  decoder_seq #(.SEL_W(3), .PULSE_LEN(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
  decoder_seq #(.SEL_W(1), .PULSE_LEN(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if));
  decoder_seq #(.SEL_W(4), .PULSE_LEN(1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(c_if));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic load_a(input logic [2:0] s, input logic [1:0] mode);
    a_if.load = 1;
    a_if.E = 1;
    a_if.s = s;
    a_if.mode = mode;
    tick();
    a_if.load = 0;
  endtask
  initial begin
    logic [7:0] rot_l [4] = '{8'h40, 8'h80, 8'h01, 8'h02};
    logic [7:0] rot_r [4] = '{8'h02, 8'h01, 8'h80, 8'h40};
    {a_if.E, a_if.load, a_if.clr, a_if.s, a_if.mode} = '0;
    {b_if.E, b_if.load, b_if.clr, b_if.s, b_if.mode} = '0;
    {c_if.E, c_if.load, c_if.clr, c_if.s, c_if.mode} = '0;
    #12;
    chk("rst_y", a_if.Y, 0);
    chk("rst_idx", a_if.idx, 0);
    chk("rst_busy", a_if.busy, 0);
    rst_n = 1;
    tick();
    chk("idle_y", a_if.Y, 0);
    for (int i = 0; i < 8; i++) begin
      load_a(3'(i), 2'b00);
      chk("dec_y", a_if.Y, 32'(8'd1 << i));
      chk("dec_idx", a_if.idx, i);
      for (int j = 0; j < 3; j++) begin
        tick();
        chk("dec_hold", a_if.Y, 32'(8'd1 << i));
        chk("dec_busy", a_if.busy, 1);
      end
    end
    load_a(3'd6, 2'b01);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      chk("rotl", a_if.Y, rot_l[i]);
    end
    load_a(3'd1, 2'b10);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      chk("rotr", a_if.Y, rot_r[i]);
    end
    load_a(3'd5, 2'b11);
    chk("pulse0", a_if.Y, 8'h20);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("pulse_on", a_if.Y, 8'h20);
    end
    tick();
    chk("pulse_off_y", a_if.Y, 0);
    chk("pulse_off_busy", a_if.busy, 0);
    load_a(3'd5, 2'b11);
    chk("stall0", a_if.Y, 8'h20);
    for (int i = 1; i < 6; i++) begin
      a_if.E = !(i == 2 || i == 3);
      tick();
      chk("stall_on", a_if.Y, 8'h20);
    end
    a_if.E = 1;
    tick();
    chk("stall_off", a_if.Y, 0);
    a_if.load = 1;
    a_if.E = 0;
    a_if.s = 3'd2;
    tick();
    a_if.load = 0;
    chk("load_no_e_y", a_if.Y, 0);
    chk("load_no_e_busy", a_if.busy, 0);
    load_a(3'd4, 2'b00);
    chk("pre_clr", a_if.Y, 8'h10);
    a_if.clr = 1;
    a_if.load = 1;
    a_if.s = 3'd1;
    tick();
    a_if.clr = 0;
    a_if.load = 0;
    chk("clr_y", a_if.Y, 0);
    chk("clr_busy", a_if.busy, 0);
    chk("clr_idx", a_if.idx, 4);
    load_a(3'd0, 2'b01);
    tick();
    chk("rot_pre", a_if.Y, 8'h02);
    load_a(3'd3, 2'b01);
    chk("reload", a_if.Y, 8'h08);
    tick();
    chk("reload_rot", a_if.Y, 8'h10);
    #2 rst_n = 0;
    #1;
    chk("arst_y", a_if.Y, 0);
    chk("arst_idx", a_if.idx, 0);
    chk("arst_busy", a_if.busy, 0);
    #2 rst_n = 1;
    tick();
    chk("post_rst", a_if.Y, 0);
    tick();
    chk("post_rst2", a_if.busy, 0);
    b_if.load = 1;
    b_if.E = 1;
    b_if.s = 1'b0;
    b_if.mode = 2'b01;
    tick();
    b_if.load = 0;
    chk("b_rot0", b_if.Y, 2'b01);
    tick();
    chk("b_rot1", b_if.Y, 2'b10);
    tick();
    chk("b_rot2", b_if.Y, 2'b01);
    b_if.load = 1;
    b_if.s = 1'b1;
    b_if.mode = 2'b11;
    tick();
    b_if.load = 0;
    chk("b_pulse_on", b_if.Y, 2'b10);
    tick();
    chk("b_pulse_off", b_if.Y, 0);
    chk("b_pulse_busy", b_if.busy, 0);
    c_if.load = 1;
    c_if.E = 1;
    c_if.s = 4'd0;
    c_if.mode = 2'b10;
    tick();
    c_if.load = 0;
    chk("c_rot0", c_if.Y, 16'h0001);
    tick();
    chk("c_wrap", c_if.Y, 16'h8000);
    chk("c_idx", c_if.idx, 15);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/decoder_seq.md
# decoder_seq

Registered, parametrised SEL_W-to-2^SEL_W one-hot decoder with sequencing modes for the RISC16bit control path. It latches a select code into a one-hot output and then holds it, rotates it left or right every enabled cycle, or emits it as a timed pulse. It sits between instruction decode and the register-file/stage enables and replaces the purely combinational 3-to-8 decoder wherever a held, stepped or pulsed select is needed.

## Interface
- SEL_W, 3, select width; OUT_W = 2**SEL_W; legal range 1..5
- PULSE_LEN, 4, output duration in pulse mode, counted in enabled cycles; legal range 1..256
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- E  in  1  enable; when low, all state is frozen except clr
- load  in  1  one-cycle strobe: accept s and mode (qualified by E)
- clr  in  1  synchronous clear of the active output; not qualified by E
- s  in  SEL_W  select code (index of the bit to drive)
- mode  in  2  00 hold, 01 rotate-left, 10 rotate-right, 11 pulse
- Y  out  OUT_W  registered one-hot output, or all zero when idle
- idx  out  SEL_W  registered current active index
- busy  out  1  registered; high while Y is non-zero

## Operation
- Reset is asynchronous and active-low: clk and rst_n are fixed as one clock plus async active-low reset. While rst_n = 0: Y = 0, idx = 0, busy = 0, internal mode_r = 00, cnt = 0.
- Two states: IDLE (busy = 0) and ACTIVE (busy = 1).
- Invariant: Y == (busy ? 1 << idx : 0) after every edge. Y is a register and is never decoded combinationally.
- Priority at each edge: clr > (load & E) > advance (busy & E) > hold.
- clr: busy <= 0, Y <= 0, cnt <= 0. idx keeps its value.
- load & E, from either state: idx <= s, mode_r <= mode, cnt <= PULSE_LEN-1, busy <= 1, Y <= 1 << s. A load while ACTIVE restarts from the new s and mode.
- load with E = 0 is ignored.
- Advance when ACTIVE, E = 1 and no load:
  - mode_r 00: hold idx.
  - mode_r 01: idx <= idx+1, mod OUT_W. Bit OUT_W-1 wraps to bit 0.
  - mode_r 10: idx <= idx-1, mod OUT_W. Bit 0 wraps to bit OUT_W-1.
  - mode_r 11: if cnt == 0, return to IDLE (busy <= 0, Y <= 0); else cnt <= cnt-1.
- E = 0 with no clr: idx, cnt, Y and busy all hold. Pulse counting stalls.
- In IDLE without load, nothing changes.
- cnt width is clog2(PULSE_LEN) with a minimum of 1. All index arithmetic is unsigned and truncated to SEL_W.

## Timing
- Load latency is 1 cycle: load sampled at edge k gives Y = 1 << s after edge k.
- Rotate: with E held high, Y moves one bit per edge, starting at edge k+1.
- Pulse: with E held high, Y is non-zero for exactly PULSE_LEN cycles (edges k .. k+PULSE_LEN-1) and is 0 after edge k+PULSE_LEN. Each E-low cycle extends the pulse by one cycle.
- busy rises and falls on the same edges as Y.
- Asserting rst_n low mid-operation clears all outputs immediately, without waiting for a clock edge. After release, the block is IDLE until the next load.

## Test plan
SEL_W = 3, PULSE_LEN = 4 unless noted.
- Exhaustive decode: for each s = 0..7, pulse load with mode 00 and E = 1 -> Y = 8'b1 << s one edge later. Y then holds for 3 further cycles; busy = 1.
- Rotate with wrap: load s = 6, mode 01, E = 1 -> Y sequence 0x40, 0x80, 0x01, 0x02. Load s = 1, mode 10 -> Y sequence 0x02, 0x01, 0x80, 0x40.
- Pulse with stall: load s = 5, mode 11 -> Y = 0x20 for 4 cycles, then 0 and busy = 0. Repeat with E = 0 for 2 mid-pulse cycles -> Y = 0x20 for 6 cycles.
- Priority: load s = 2 with E = 0 -> no change. Assert clr and load together -> Y = 0. Load s = 3 while rotating -> Y = 0x08 on the next edge, and rotation restarts from bit 3.
- Async reset: drop rst_n between clock edges mid-rotate -> Y = 0, idx = 0, busy = 0 before the next edge. After release with no load, Y stays 0.
- Parameter sweep: SEL_W = 1 and 4, PULSE_LEN = 1 -> with SEL_W = 1, rotate alternates 01/10. With PULSE_LEN = 1, the pulse lasts exactly 1 cycle.
